clock_set_ctrl: RTL and testbench

// - Mode/set controller for the HH:MM:SS chain (mod60 sec, mod60 min, mod12 hr), sits between board keys and the counters.
// - Debounces two pushbuttons; RUN gates the seconds-counter enable; SET_HR/SET_MT/SET_SC edit a shadow copy of the time.
// - Leaving SET_SC loads the edited time into the counters. Drives a per-digit blank mask that blinks the field being edited.

---
 rtl/clock_set_ctrl_pkg.sv | 47 ++++
 rtl/clock_set_ctrl_key.sv | 59 +++++
 rtl/clock_set_ctrl.sv | 175 +++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock mode/set controller.
//   state_e     : controller states, encoded as they appear on the mode port
//   *_W         : packed BCD field widths
//   *_MAX       : highest legal value of each field (packed BCD)
//   bcd_inc7/5  : wrap-around BCD increment of a 7-bit / 5-bit packed field
package clock_set_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_SET_HR = 2'b01,
        ST_SET_MT = 2'b10,
        ST_SET_SC = 2'b11
    } state_e;

    localparam int unsigned SC_W = 7;
    localparam int unsigned MT_W = 7;
    localparam int unsigned HR_W = 5;

    localparam logic [SC_W-1:0] SC_MAX = 7'h59;
    localparam logic [MT_W-1:0] MT_MAX = 7'h59;
    localparam logic [HR_W-1:0] HR_MAX = 5'h11;

    // Packed BCD compares in the same order as the value it encodes, so the
    // ">= max" test also catches illegal snapshots with tens over range.
    function automatic logic [6:0] bcd_inc7(input logic [6:0] v, input logic [6:0] vmax);
        logic [6:0] r;
        if (v >= vmax)
            r = '0;
        else if (v[3:0] >= 4'd9)
            r = {v[6:4] + 3'd1, 4'd0};
        else
            r = {v[6:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [4:0] bcd_inc5(input logic [4:0] v, input logic [4:0] vmax);
        logic [4:0] r;
        if (v >= vmax)
            r = '0;
        else if (v[3:0] >= 4'd9)
            r = {v[4] + 1'b1, 4'd0};
        else
            r = {v[4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_key.sv
// Pushbutton conditioner: two-flop synchroniser, stability counter and
// falling-edge detector on the accepted level.
//   clk_50 : system clock
//   rst_n  : asynchronous reset, active low
//   key_n  : raw pushbutton, active low, asynchronous
//   press  : one-cycle pulse when the accepted level goes released -> pressed
module key_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q,   sync_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          stable_q, stable_d;
    logic          press_q,  press_d;

    always_comb begin
        sync_d   = {sync_q[0], key_n};
        cnt_d    = cnt_q;
        stable_d = stable_q;
        // Counter only runs while the synced sample disagrees with the
        // accepted level; any agreeing sample restarts the window.
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
        press_d = stable_q & ~stable_d;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '1;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the HH:MM:SS counter chain.
//   clk_50, rst_n          : clock, asynchronous active-low reset
//   en                     : run switch level
//   key_mode_n, key_inc_n  : raw active-low pushbuttons
//   cur_sc/cur_mt/cur_hr   : live time, packed BCD
//   run_en                 : seconds counter enable
//   load, ld_sc/mt/hr      : one-cycle load of the edited time into the counters
//   mode                   : 00 RUN, 01 SET_HR, 10 SET_MT, 11 SET_SC
//   blank                  : per-digit blank (bit i = HEXi), blinks the edited field
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned BLINK_DIV = 12_500_000
) (
    input  logic            clk_50,
    input  logic            rst_n,
    input  logic            en,
    input  logic            key_mode_n,
    input  logic            key_inc_n,
    input  logic [SC_W-1:0] cur_sc,
    input  logic [MT_W-1:0] cur_mt,
    input  logic [HR_W-1:0] cur_hr,
    output logic            run_en,
    output logic            load,
    output logic [SC_W-1:0] ld_sc,
    output logic [MT_W-1:0] ld_mt,
    output logic [HR_W-1:0] ld_hr,
    output logic [1:0]      mode,
    output logic [5:0]      blank
);

    localparam int unsigned BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic mode_press, inc_press;

    state_e state_q, state_d;

    logic [SC_W-1:0] sh_sc_q, sh_sc_d;
    logic [MT_W-1:0] sh_mt_q, sh_mt_d;
    logic [HR_W-1:0] sh_hr_q, sh_hr_d;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    logic            run_en_q, run_en_d;
    logic            load_q,   load_d;
    logic [SC_W-1:0] ld_sc_q,  ld_sc_d;
    logic [MT_W-1:0] ld_mt_q,  ld_mt_d;
    logic [HR_W-1:0] ld_hr_q,  ld_hr_d;
    logic [5:0]      blank_q,  blank_d;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .key_n  (key_mode_n),
        .press  (mode_press)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .key_n  (key_inc_n),
        .press  (inc_press)
    );

    // State register
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // Next state: every mode press steps one state round the ring
    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            case (state_q)
                ST_RUN:    state_d = ST_SET_HR;
                ST_SET_HR: state_d = ST_SET_MT;
                ST_SET_MT: state_d = ST_SET_SC;
                ST_SET_SC: state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // Shadow time and blink divider
    always_comb begin
        sh_sc_d = sh_sc_q;
        sh_mt_d = sh_mt_q;
        sh_hr_d = sh_hr_q;
        // A mode press takes priority, so a coincident inc is dropped.
        if (mode_press) begin
            if (state_q == ST_RUN) begin
                sh_sc_d = cur_sc;
                sh_mt_d = cur_mt;
                sh_hr_d = cur_hr;
            end
        end else if (inc_press) begin
            case (state_q)
                ST_SET_HR: sh_hr_d = bcd_inc5(sh_hr_q, HR_MAX);
                ST_SET_MT: sh_mt_d = bcd_inc7(sh_mt_q, MT_MAX);
                ST_SET_SC: sh_sc_d = bcd_inc7(sh_sc_q, SC_MAX);
                default: ;
            endcase
        end

        if (state_d != state_q) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            phase_d     = phase_q;
        end
    end

    // Outputs: computed from next-state values so that the registered
    // outputs change on the same edge as the state itself.
    always_comb begin
        load_d   = mode_press && (state_q == ST_SET_SC);
        ld_sc_d  = load_d ? sh_sc_q : ld_sc_q;
        ld_mt_d  = load_d ? sh_mt_q : ld_mt_q;
        ld_hr_d  = load_d ? sh_hr_q : ld_hr_q;
        run_en_d = en & (state_d == ST_RUN) & ~load_d;
        case (state_d)
            ST_SET_HR: blank_d = {phase_d, phase_d, 4'b0000};
            ST_SET_MT: blank_d = {2'b00, phase_d, phase_d, 2'b00};
            ST_SET_SC: blank_d = {4'b0000, phase_d, phase_d};
            default:   blank_d = '0;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sh_sc_q     <= '0;
            sh_mt_q     <= '0;
            sh_hr_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            run_en_q    <= 1'b0;
            load_q      <= 1'b0;
            ld_sc_q     <= '0;
            ld_mt_q     <= '0;
            ld_hr_q     <= '0;
            blank_q     <= '0;
        end else begin
            sh_sc_q     <= sh_sc_d;
            sh_mt_q     <= sh_mt_d;
            sh_hr_q     <= sh_hr_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            run_en_q    <= run_en_d;
            load_q      <= load_d;
            ld_sc_q     <= ld_sc_d;
            ld_mt_q     <= ld_mt_d;
            ld_hr_q     <= ld_hr_d;
            blank_q     <= blank_d;
        end
    end

    assign run_en = run_en_q;
    assign load   = load_q;
    assign ld_sc  = ld_sc_q;
    assign ld_mt  = ld_mt_q;
    assign ld_hr  = ld_hr_q;
    assign mode   = state_q;
    assign blank  = blank_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with DB_CYCLES=4, BLINK_DIV=8.
// Stimulus pushes expected mode/load events into a queue; a monitor pops
// one entry for every mode change or load pulse the DUT shows.
module tb_clock_set_ctrl;

    localparam int DB  = 4;
    localparam int BD  = 8;

    logic       clk_50 = 1'b0;
    logic       rst_n;
    logic       en;
    logic       key_mode_n, key_inc_n;
    logic [6:0] cur_sc, cur_mt;
    logic [4:0] cur_hr;
    logic       run_en, load;
    logic [6:0] ld_sc, ld_mt;
    logic [4:0] ld_hr;
    logic [1:0] mode;
    logic [5:0] blank;

    clock_set_ctrl #(.DB_CYCLES(DB), .BLINK_DIV(BD)) dut (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .en         (en),
        .key_mode_n (key_mode_n),
        .key_inc_n  (key_inc_n),
        .cur_sc     (cur_sc),
        .cur_mt     (cur_mt),
        .cur_hr     (cur_hr),
        .run_en     (run_en),
        .load       (load),
        .ld_sc      (ld_sc),
        .ld_mt      (ld_mt),
        .ld_hr      (ld_hr),
        .mode       (mode),
        .blank      (blank)
    );

    always #5 clk_50 = ~clk_50;

    typedef struct packed {
        logic [1:0] mode;
        logic       load;
        logic [4:0] hr;
        logic [6:0] mt;
        logic [6:0] sc;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: state index and shadows as plain decimal numbers
    int m_state = 0;
    int m_hr = 0, m_mt = 0, m_sc = 0;
    int c_hr = 0, c_mt = 0, c_sc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int inc_wrap(input int v, input int mx);
        return (v >= mx) ? 0 : v + 1;
    endfunction

    function automatic logic [6:0] bcd7(input int v);
        return 7'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [4:0] bcd5(input int v);
        return 5'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [5:0] blank_for(input int st, input int elapsed);
        logic ph;
        ph = ((elapsed / BD) % 2) == 1;
        case (st)
            1:       return {ph, ph, 4'b0000};
            2:       return {2'b00, ph, ph, 2'b00};
            3:       return {4'b0000, ph, ph};
            default: return 6'b000000;
        endcase
    endfunction

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         entry_cyc = 0;
    int         exp_mode = 0;
    logic [1:0] prev_mode = 2'b00;
    bit         run_next = 1'b0;
    exp_t       got;

    always @(negedge clk_50) begin
        cyc++;
        if (rst_n !== 1'b1) begin
            prev_mode = 2'b00;
            exp_mode  = 0;
            entry_cyc = cyc;
            run_next  = 1'b0;
        end else begin
            if (run_next) begin
                chk("run_en_after_load", 32'(run_en), 32'd1);
                run_next = 1'b0;
            end
            if (mode !== prev_mode || load !== 1'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event_mode_load", {30'd0, mode} + 32'(load) * 4, {30'd0, prev_mode});
                end else begin
                    got = sb.pop_front();
                    chk("event_mode", 32'(mode), 32'(got.mode));
                    chk("event_load", 32'(load), 32'(got.load));
                    if (got.load) begin
                        chk("ld_hr", 32'(ld_hr), 32'(got.hr));
                        chk("ld_mt", 32'(ld_mt), 32'(got.mt));
                        chk("ld_sc", 32'(ld_sc), 32'(got.sc));
                        chk("run_en_during_load", 32'(run_en), 32'd0);
                        run_next = 1'b1;
                    end
                    if (got.mode != 2'b00)
                        chk("run_en_in_set", 32'(run_en), 32'd0);
                    exp_mode  = int'(got.mode);
                    entry_cyc = cyc;
                end
            end
            chk("blank", 32'(blank), 32'(blank_for(exp_mode, cyc - entry_cyc)));
            prev_mode = mode;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic drive_cur();
        cur_hr = bcd5(c_hr);
        cur_mt = bcd7(c_mt);
        cur_sc = bcd7(c_sc);
    endtask

    task automatic press_keys(input bit m, input bit i);
        key_mode_n = ~m;
        key_inc_n  = ~i;
        tick(2 * DB + 2);
        key_mode_n = 1'b1;
        key_inc_n  = 1'b1;
        tick(2 * DB + 2);
        chk("event_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic push_mode_event();
        exp_t e;
        e = '0;
        if (m_state == 0) begin
            m_hr = c_hr; m_mt = c_mt; m_sc = c_sc;
            m_state = 1;
        end else if (m_state < 3) begin
            m_state++;
        end else begin
            m_state = 0;
            e.load = 1'b1;
            e.hr = bcd5(m_hr);
            e.mt = bcd7(m_mt);
            e.sc = bcd7(m_sc);
        end
        e.mode = 2'(m_state);
        sb.push_back(e);
    endtask

    task automatic do_mode(input bit with_inc);
        push_mode_event();
        press_keys(1'b1, with_inc);
    endtask

    task automatic do_inc();
        case (m_state)
            1: m_hr = inc_wrap(m_hr, 11);
            2: m_mt = inc_wrap(m_mt, 59);
            3: m_sc = inc_wrap(m_sc, 59);
            default: ;
        endcase
        press_keys(1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; key_mode_n = 1'b1; key_inc_n = 1'b1;
        c_hr = 11; c_mt = 58; c_sc = 9;
        drive_cur();
        tick(3);
        chk("rst_run_en", 32'(run_en), 32'd0);
        chk("rst_load",   32'(load),   32'd0);
        chk("rst_mode",   32'(mode),   32'd0);
        chk("rst_blank",  32'(blank),  32'd0);
        chk("rst_ld", {13'd0, ld_hr, ld_mt, ld_sc}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        chk("run_en_after_release", 32'(run_en), 32'd1);

        // en low gates run_en in RUN
        en = 1'b0; tick(2);
        chk("run_en_en_low", 32'(run_en), 32'd0);
        en = 1'b1; tick(2);
        chk("run_en_en_high", 32'(run_en), 32'd1);

        // inc in RUN is ignored (monitor flags any event)
        press_keys(1'b0, 1'b1);

        // too-short press: no event
        key_mode_n = 1'b0; tick(3); key_mode_n = 1'b1; tick(12);
        chk("short_press_mode", 32'(mode), 32'd0);

        // bouncy press: exactly one press
        push_mode_event();
        key_mode_n = 1'b0; tick(2); key_mode_n = 1'b1; tick(1);
        press_keys(1'b1, 1'b0);
        chk("bounce_mode", 32'(mode), 32'd1);
        chk("bounce_run_en", 32'(run_en), 32'd0);

        // directed edit: 11:58:09 -> hr 00, mt 00, sc 10
        do_inc();
        do_mode(1'b0);
        do_inc(); do_inc();
        tick(20);                 // let SET_MT blink through a full period
        do_mode(1'b0);
        do_inc();
        do_mode(1'b0);
        chk("directed_mode", 32'(mode), 32'd0);

        // mode and inc together in SET_HR: mode wins
        c_hr = 7; c_mt = 30; c_sc = 45; drive_cur();
        do_mode(1'b0);
        do_mode(1'b1);
        chk("simul_mode", 32'(mode), 32'd2);
        do_mode(1'b0);
        do_mode(1'b0);

        // randomized edits
        for (int it = 0; it < 16; it++) begin
            c_hr = $urandom_range(11); c_mt = $urandom_range(59); c_sc = $urandom_range(59);
            drive_cur();
            if ($urandom_range(3) == 0) do_inc();
            do_mode($urandom_range(3) == 0);
            for (int k = 0, n = $urandom_range(13); k < n; k++) do_inc();
            do_mode($urandom_range(3) == 0);
            for (int k = 0, n = $urandom_range(3); k < n; k++) do_inc();
            do_mode($urandom_range(3) == 0);
            for (int k = 0, n = $urandom_range(3); k < n; k++) do_inc();
            do_mode(1'b0);
        end

        // reset mid-edit in SET_SC: no load, all outputs back to reset values
        c_hr = 3; c_mt = 14; c_sc = 15; drive_cur();
        do_mode(1'b0); do_inc(); do_mode(1'b0); do_inc(); do_mode(1'b0); do_inc();
        chk("pre_reset_mode", 32'(mode), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mode",   32'(mode),   32'd0);
        chk("async_rst_load",   32'(load),   32'd0);
        chk("async_rst_run_en", 32'(run_en), 32'd0);
        chk("async_rst_blank",  32'(blank),  32'd0);
        chk("async_rst_ld", {13'd0, ld_hr, ld_mt, ld_sc}, 32'd0);
        m_state = 0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_run_en", 32'(run_en), 32'd1);
        chk("post_rst_mode",   32'(mode),   32'd0);
        tick(20);
        chk("post_rst_load",   32'(load),   32'd0);

        // fresh edit after reset uses a new snapshot
        c_hr = 10; c_mt = 59; c_sc = 59; drive_cur();
        do_mode(1'b0); do_inc(); do_mode(1'b0); do_inc(); do_mode(1'b0); do_inc(); do_mode(1'b0);

        tick(4);
        chk("queue_empty_end", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
